// File: rtl/path_trace32_pkg.sv
// Shared definitions for the wavefront fabric and its path tracer: memory map,
// grid geometry, predecessor direction codes and nibble/entry packing helpers.
package path_trace32_pkg;

  localparam logic [31:0] ADDR_MAP  = 32'h4000_1000;
  localparam logic [31:0] ADDR_DIR  = 32'h4000_2000;
  localparam logic [31:0] ADDR_PATH = 32'h4000_3000;

  localparam int GRID_DIM  = 32;
  localparam int COORD_W   = $clog2(GRID_DIM);
  localparam int MAX_STEPS = 1024;

  localparam logic [COORD_W-1:0] EDGE_MAX = COORD_W'(GRID_DIM - 1);
  localparam logic [10:0]        MAX_LEN  = 11'(MAX_STEPS);

  // Predecessor codes: the neighbour the wavefront arrived from.
  localparam logic [3:0] DIR_ORIGIN = 4'd0;
  localparam logic [3:0] DIR_N      = 4'd1;
  localparam logic [3:0] DIR_E      = 4'd2;
  localparam logic [3:0] DIR_S      = 4'd3;
  localparam logic [3:0] DIR_W      = 4'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_RD_WAIT,
    ST_DECODE,
    ST_WRITE,
    ST_WR_WAIT,
    ST_DONE
  } state_e;

  function automatic logic [3:0] get_nibble(input logic [31:0] word, input logic [2:0] idx);
    return word[{idx, 2'b00} +: 4];
  endfunction

  function automatic logic [15:0] make_entry(input logic [9:0] node);
    return {6'd0, node};
  endfunction

  function automatic logic [31:0] put_lane(input logic [31:0] word, input logic lane,
                                           input logic [15:0] entry);
    logic [31:0] w;
    w = word;
    if (lane) w[31:16] = entry;
    else      w[15:0]  = entry;
    return w;
  endfunction

endpackage

// File: rtl/path_step32.sv
// One backward step on the 32x32 grid: coordinate plus predecessor code gives the
// neighbour coordinate, flagging invalid codes and moves that would leave the grid.
module path_step32
  import path_trace32_pkg::*;
(
  input  logic [COORD_W-1:0] x_i,
  input  logic [COORD_W-1:0] y_i,
  input  logic [3:0]         dir_i,
  output logic [COORD_W-1:0] x_o,
  output logic [COORD_W-1:0] y_o,
  output logic               bad_o
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
    x_o   = x_i;
    y_o   = y_i;
    bad_o = 1'b0;
    case (dir_i)
      DIR_ORIGIN: begin end
      DIR_N: if (y_i == '0)      bad_o = 1'b1; else y_o = y_i - 1'b1;
      DIR_E: if (x_i == EDGE_MAX) bad_o = 1'b1; else x_o = x_i + 1'b1;
      DIR_S: if (y_i == EDGE_MAX) bad_o = 1'b1; else y_o = y_i + 1'b1;
      DIR_W: if (x_i == '0)      bad_o = 1'b1; else x_o = x_i - 1'b1;
      default:                   bad_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/path_trace32.sv
// Path tracer: walks the packed predecessor map from dest back to the origin and writes
// two 16-bit coordinate entries per path word. Optional last-word cache: TRACE_CACHE_EN.
module path_trace32
  import path_trace32_pkg::*;
(
  input  logic        clk,
  input  logic        arst_n,
  input  logic        ctrl_wr,
  input  logic [31:0] ctrl_in,
  output logic [31:0] ctrl_out,
  output logic [10:0] path_len,
  input  logic        txn_rdy,
  input  logic [31:0] txn_rdata,
  output logic [31:0] txn_wdata,
  output logic [31:0] txn_addr,
  output logic        txn_req,
  output logic        txn_wr,
  output logic        int_done
);

  state_e      state_q;
  logic        run_q, done_q, err_q;
  logic [9:0]  dest_q, cur_q, nxt_q;
  logic [10:0] path_len_q;
  logic        lane_q;
  logic [8:0]  wr_idx_q;
  logic [31:0] buf_q, word_q;
  logic        term_q, term_err_q, abort_q;
  logic        txn_req_q, txn_wr_q, int_done_q;
  logic [31:0] txn_addr_q, txn_wdata_q;

  logic [3:0]         dir;
  logic [COORD_W-1:0] nxt_x, nxt_y;
  logic               step_bad;
  logic [10:0]        len_inc;
  logic               is_origin, hit_limit, terminal;
  logic               abort_req, start_go, rd_accept, cache_hit;
  logic               unused_ctrl;

  assign dir = get_nibble(word_q, cur_q[2:0]);

  path_step32 u_step (
    .x_i   (cur_q[4:0]),
    .y_i   (cur_q[9:5]),
    .dir_i (dir),
    .x_o   (nxt_x),
    .y_o   (nxt_y),
    .bad_o (step_bad)
  );

  assign len_inc   = path_len_q + 11'd1;
  assign is_origin = (dir == DIR_ORIGIN);
  assign hit_limit = (len_inc == MAX_LEN) && !is_origin;
  assign terminal  = is_origin || step_bad || hit_limit;

  assign abort_req = ctrl_wr && !ctrl_in[31] && (state_q != ST_IDLE);
  assign start_go  = (state_q == ST_IDLE) && run_q && !ctrl_wr;
  assign rd_accept = (state_q == ST_RD_WAIT) && txn_rdy && !abort_q && !abort_req;

`ifdef TRACE_CACHE_EN
  logic       cache_valid_q;
  logic [6:0] cache_idx_q;

  // word_q doubles as the cached data; only its index and validity are tracked here.
  assign cache_hit = cache_valid_q && (cache_idx_q == cur_q[9:3]);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cache_valid_q <= 1'b0;
      cache_idx_q   <= '0;
    end else if (start_go || abort_req) begin
      cache_valid_q <= 1'b0;
    end else if (rd_accept) begin
      cache_valid_q <= 1'b1;
      cache_idx_q   <= cur_q[9:3];
    end
  end
`else
  assign cache_hit = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= ST_IDLE;
      run_q       <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      dest_q      <= '0;
      cur_q       <= '0;
      nxt_q       <= '0;
      path_len_q  <= '0;
      lane_q      <= 1'b0;
      wr_idx_q    <= '0;
      buf_q       <= '0;
      word_q      <= '0;
      term_q      <= 1'b0;
      term_err_q  <= 1'b0;
      abort_q     <= 1'b0;
      txn_req_q   <= 1'b0;
      txn_wr_q    <= 1'b0;
      txn_addr_q  <= '0;
      txn_wdata_q <= '0;
      int_done_q  <= 1'b0;
    end else begin
      txn_req_q  <= 1'b0;
      int_done_q <= 1'b0;
      if (abort_req) run_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (ctrl_wr) begin
            run_q  <= ctrl_in[31];
            dest_q <= ctrl_in[9:0];
            if (ctrl_in[31]) begin
              done_q     <= 1'b0;
              err_q      <= 1'b0;
              path_len_q <= '0;
            end
          end else if (run_q) begin
            cur_q    <= dest_q;
            lane_q   <= 1'b0;
            wr_idx_q <= '0;
            buf_q    <= '0;
            term_q   <= 1'b0;
            abort_q  <= 1'b0;
            state_q  <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (abort_req)      state_q <= ST_IDLE;
          else if (cache_hit) state_q <= ST_DECODE;
          else begin
            txn_req_q  <= 1'b1;
            txn_wr_q   <= 1'b0;
            txn_addr_q <= ADDR_DIR + {23'd0, cur_q[9:3], 2'b00};
            state_q    <= ST_RD_WAIT;
          end
        end
        ST_RD_WAIT: begin
          if (abort_req) abort_q <= 1'b1;
          if (txn_rdy) begin
            if (abort_q || abort_req) state_q <= ST_IDLE;
            else begin
              word_q  <= txn_rdata;
              state_q <= ST_DECODE;
            end
          end
        end
        ST_DECODE: begin
          if (abort_req) state_q <= ST_IDLE;
          else begin
            buf_q      <= put_lane(buf_q, lane_q, make_entry(cur_q));
            path_len_q <= len_inc;
            nxt_q      <= {nxt_y, nxt_x};
            term_q     <= terminal;
            term_err_q <= !is_origin;
            if (terminal || lane_q) state_q <= ST_WRITE;
            else begin
              lane_q  <= 1'b1;
              cur_q   <= {nxt_y, nxt_x};
              state_q <= ST_FETCH;
            end
          end
        end
        ST_WRITE: begin
          if (abort_req) state_q <= ST_IDLE;
          else begin
            txn_req_q   <= 1'b1;
            txn_wr_q    <= 1'b1;
            txn_addr_q  <= ADDR_PATH + {21'd0, wr_idx_q, 2'b00};
            txn_wdata_q <= buf_q;
            state_q     <= ST_WR_WAIT;
          end
        end
        ST_WR_WAIT: begin
          if (abort_req) abort_q <= 1'b1;
          if (txn_rdy) begin
            if (abort_q || abort_req) state_q <= ST_IDLE;
            else begin
              wr_idx_q <= wr_idx_q + 9'd1;
              buf_q    <= '0;
              lane_q   <= 1'b0;
              if (term_q) state_q <= ST_DONE;
              else begin
                cur_q   <= nxt_q;
                state_q <= ST_FETCH;
              end
            end
          end
        end
        ST_DONE: begin
          if (!abort_req) begin
            done_q     <= 1'b1;
            err_q      <= term_err_q;
            run_q      <= 1'b0;
            int_done_q <= 1'b1;
          end
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign unused_ctrl = ^ctrl_in[30:10];

  assign ctrl_out  = {run_q, 15'd0, done_q, err_q, 4'd0, dest_q};
  assign path_len  = path_len_q;
  assign txn_req   = txn_req_q;
  assign txn_wr    = txn_wr_q;
  assign txn_addr  = txn_addr_q;
  assign txn_wdata = txn_wdata_q;
  assign int_done  = int_done_q;

endmodule

// File: tb/tb_path_trace32.sv
// Directed self-checking bench for path_trace32 with a small word-memory responder.
module tb_path_trace32;

  localparam logic [31:0] ADDR_DIR  = 32'h4000_2000;
  localparam logic [31:0] ADDR_PATH = 32'h4000_3000;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        ctrl_wr;
  logic [31:0] ctrl_in;
  logic [31:0] ctrl_out;
  logic [10:0] path_len;
  logic        txn_rdy;
  logic [31:0] txn_rdata;
  logic [31:0] txn_wdata;
  logic [31:0] txn_addr;
  logic        txn_req;
  logic        txn_wr;
  logic        int_done;

  int checks   = 0;
  int failures = 0;

  logic [31:0] dir_mem [128];
  logic [31:0] wr_data_log [2048];
  logic [31:0] wr_addr_log [2048];
  int mem_lat     = 0;
  int reads_n     = 0;
  int writes_n    = 0;
  int bad_addr_n  = 0;
  int done_pulses = 0;

  always #5 clk = ~clk;

  path_trace32 dut (
    .clk       (clk),
    .arst_n    (arst_n),
    .ctrl_wr   (ctrl_wr),
    .ctrl_in   (ctrl_in),
    .ctrl_out  (ctrl_out),
    .path_len  (path_len),
    .txn_rdy   (txn_rdy),
    .txn_rdata (txn_rdata),
    .txn_wdata (txn_wdata),
    .txn_addr  (txn_addr),
    .txn_req   (txn_req),
    .txn_wr    (txn_wr),
    .int_done  (int_done)
  );

  // Memory responder: samples requests on the falling edge, answers after mem_lat cycles.
  initial begin : responder
    logic [31:0] a;
    logic [31:0] rd;
    int idx;
    txn_rdy   = 1'b0;
    txn_rdata = '0;
    forever begin
      @(negedge clk);
      if (arst_n === 1'b1 && txn_req === 1'b1) begin
        a  = txn_addr;
        rd = 32'hFFFF_FFFF;
        if (txn_wr) begin
          if (a < ADDR_PATH || a >= ADDR_PATH + 32'd2048 || a[1:0] != 2'b00) bad_addr_n++;
          if (writes_n < 2048) begin
            wr_data_log[writes_n] = txn_wdata;
            wr_addr_log[writes_n] = a;
          end
          writes_n++;
        end else begin
          if (a >= ADDR_DIR && a < ADDR_DIR + 32'd512 && a[1:0] == 2'b00) begin
            idx = int'((a - ADDR_DIR) >> 2);
            rd  = dir_mem[idx];
          end else bad_addr_n++;
          reads_n++;
        end
        repeat (mem_lat) @(negedge clk);
        txn_rdy   = 1'b1;
        txn_rdata = rd;
        @(negedge clk);
        txn_rdy = 1'b0;
      end
    end
  end

  always @(negedge clk) if (int_done === 1'b1) done_pulses++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic clear_map();
    for (int i = 0; i < 128; i++) dir_mem[i] = 32'hFFFF_FFFF;
  endtask

  task automatic start(input logic [4:0] x, input logic [4:0] y);
    @(negedge clk);
    ctrl_wr = 1'b1;
    ctrl_in = {1'b1, 21'd0, y, x};
    @(negedge clk);
    ctrl_wr = 1'b0;
    ctrl_in = '0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (ctrl_out[15] !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (ctrl_out[15] !== 1'b1) begin
      failures++;
      $display("FAIL %s_timeout done=%b after %0d cycles", name, ctrl_out[15], n);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    arst_n  = 1'b0;
    ctrl_wr = 1'b0;
    ctrl_in = '0;
    repeat (3) @(negedge clk);
    checks += 7;
    if (ctrl_out !== 32'h0) begin failures++; $display("FAIL reset_ctrl_out got=%h exp=%h", ctrl_out, 32'h0); end
    if (path_len !== 11'd0) begin failures++; $display("FAIL reset_path_len got=%0d exp=0", path_len); end
    if (txn_req !== 1'b0) begin failures++; $display("FAIL reset_txn_req got=%b exp=0", txn_req); end
    if (txn_wr !== 1'b0) begin failures++; $display("FAIL reset_txn_wr got=%b exp=0", txn_wr); end
    if (txn_addr !== 32'h0) begin failures++; $display("FAIL reset_txn_addr got=%h exp=0", txn_addr); end
    if (txn_wdata !== 32'h0) begin failures++; $display("FAIL reset_txn_wdata got=%h exp=0", txn_wdata); end
    if (int_done !== 1'b0) begin failures++; $display("FAIL reset_int_done got=%b exp=0", int_done); end
    arst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // node0=ORIGIN, node1=W, node2=W; dest (2,0).
  task automatic test_basic(input string name);
    int r0, w0, p0, exp_reads;
    clear_map();
    dir_mem[0] = 32'hFFFF_F440;
    r0 = reads_n; w0 = writes_n; p0 = done_pulses;
`ifdef TRACE_CACHE_EN
    exp_reads = 1;
`else
    exp_reads = 3;
`endif
    start(5'd2, 5'd0);
    wait_done(name, 200);
    checks += 8;
    if (writes_n - w0 !== 2) begin failures++; $display("FAIL %s_writes got=%0d exp=2", name, writes_n - w0); end
    if (wr_data_log[w0] !== 32'h0001_0002) begin failures++; $display("FAIL %s_word0 got=%h exp=00010002", name, wr_data_log[w0]); end
    if (wr_data_log[w0+1] !== 32'h0) begin failures++; $display("FAIL %s_word1 got=%h exp=00000000", name, wr_data_log[w0+1]); end
    if (wr_addr_log[w0+1] !== ADDR_PATH + 32'd4) begin failures++; $display("FAIL %s_addr1 got=%h exp=%h", name, wr_addr_log[w0+1], ADDR_PATH + 32'd4); end
    if (path_len !== 11'd3) begin failures++; $display("FAIL %s_path_len got=%0d exp=3", name, path_len); end
    if (ctrl_out !== 32'h0000_8002) begin failures++; $display("FAIL %s_ctrl_out got=%h exp=00008002", name, ctrl_out); end
    if (done_pulses - p0 !== 1) begin failures++; $display("FAIL %s_int_done_pulses got=%0d exp=1", name, done_pulses - p0); end
    if (reads_n - r0 !== exp_reads) begin failures++; $display("FAIL %s_reads got=%0d exp=%0d", name, reads_n - r0, exp_reads); end
  endtask

  // Dest (5,3) = node 101: word 12, nibble 5 is ORIGIN.
  task automatic test_single();
    int w0;
    clear_map();
    dir_mem[12] = 32'hFF0F_FFFF;
    w0 = writes_n;
    start(5'd5, 5'd3);
    wait_done("single", 200);
    checks += 5;
    if (writes_n - w0 !== 1) begin failures++; $display("FAIL single_writes got=%0d exp=1", writes_n - w0); end
    if (wr_data_log[w0] !== 32'h0000_0065) begin failures++; $display("FAIL single_word got=%h exp=00000065", wr_data_log[w0]); end
    if (wr_addr_log[w0] !== ADDR_PATH) begin failures++; $display("FAIL single_addr got=%h exp=%h", wr_addr_log[w0], ADDR_PATH); end
    if (path_len !== 11'd1) begin failures++; $display("FAIL single_path_len got=%0d exp=1", path_len); end
    if (ctrl_out !== 32'h0000_8065) begin failures++; $display("FAIL single_ctrl_out got=%h exp=00008065", ctrl_out); end
  endtask

  // Dest (0,4) = node 128 points W off the grid edge.
  task automatic test_edge_err();
    int w0;
    clear_map();
    dir_mem[16] = 32'hFFFF_FFF4;
    w0 = writes_n;
    start(5'd0, 5'd4);
    wait_done("edge", 200);
    checks += 4;
    if (writes_n - w0 !== 1) begin failures++; $display("FAIL edge_writes got=%0d exp=1", writes_n - w0); end
    if (wr_data_log[w0] !== 32'h0000_0080) begin failures++; $display("FAIL edge_word got=%h exp=00000080", wr_data_log[w0]); end
    if (path_len !== 11'd1) begin failures++; $display("FAIL edge_path_len got=%0d exp=1", path_len); end
    if (ctrl_out !== 32'h0000_C080) begin failures++; $display("FAIL edge_ctrl_out got=%h exp=0000c080", ctrl_out); end
  endtask

  // node0=E, node1=W: endless loop stopped by the step limit.
  task automatic test_loop_limit();
    int w0, bad_words;
    clear_map();
    dir_mem[0] = 32'hFFFF_FF42;
    w0 = writes_n;
    start(5'd0, 5'd0);
    wait_done("loop", 20000);
    bad_words = 0;
    for (int i = 0; i < 512; i++) if (wr_data_log[w0+i] !== 32'h0001_0000) bad_words++;
    checks += 5;
    if (writes_n - w0 !== 512) begin failures++; $display("FAIL loop_writes got=%0d exp=512", writes_n - w0); end
    if (bad_words !== 0) begin failures++; $display("FAIL loop_words bad=%0d exp=0", bad_words); end
    if (wr_addr_log[w0+511] !== ADDR_PATH + 32'd2044) begin failures++; $display("FAIL loop_last_addr got=%h exp=%h", wr_addr_log[w0+511], ADDR_PATH + 32'd2044); end
    if (path_len !== 11'd1024) begin failures++; $display("FAIL loop_path_len got=%0d exp=1024", path_len); end
    if (ctrl_out !== 32'h0000_C000) begin failures++; $display("FAIL loop_ctrl_out got=%h exp=0000c000", ctrl_out); end
  endtask

  task automatic test_abort();
    int r0, w0, p0, n;
    clear_map();
    dir_mem[0] = 32'hFFFF_F440;
    mem_lat = 5;
    r0 = reads_n; w0 = writes_n; p0 = done_pulses;
    start(5'd2, 5'd0);
    n = 0;
    while (txn_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (txn_req !== 1'b1) begin failures++; $display("FAIL abort_req_seen got=%b exp=1", txn_req); end
    ctrl_wr = 1'b1;
    ctrl_in = 32'h0;
    @(negedge clk);
    ctrl_wr = 1'b0;
    repeat (20) @(negedge clk);
    mem_lat = 0;
    checks += 6;
    if (reads_n - r0 !== 1) begin failures++; $display("FAIL abort_reads got=%0d exp=1", reads_n - r0); end
    if (writes_n - w0 !== 0) begin failures++; $display("FAIL abort_writes got=%0d exp=0", writes_n - w0); end
    if (done_pulses - p0 !== 0) begin failures++; $display("FAIL abort_int_done got=%0d exp=0", done_pulses - p0); end
    if (ctrl_out[15] !== 1'b0) begin failures++; $display("FAIL abort_done got=%b exp=0", ctrl_out[15]); end
    if (ctrl_out[31] !== 1'b0) begin failures++; $display("FAIL abort_run got=%b exp=0", ctrl_out[31]); end
    if (txn_req !== 1'b0) begin failures++; $display("FAIL abort_txn_req got=%b exp=0", txn_req); end
  endtask

  // Nodes 7..1 point W, node0 ORIGIN, all in directory word 0.
  task automatic test_straight8();
    int r0, w0, exp_reads;
    clear_map();
    dir_mem[0] = 32'h4444_4440;
    r0 = reads_n; w0 = writes_n;
`ifdef TRACE_CACHE_EN
    exp_reads = 1;
`else
    exp_reads = 8;
`endif
    start(5'd7, 5'd0);
    wait_done("straight", 300);
    checks += 7;
    if (reads_n - r0 !== exp_reads) begin failures++; $display("FAIL straight_reads got=%0d exp=%0d", reads_n - r0, exp_reads); end
    if (writes_n - w0 !== 4) begin failures++; $display("FAIL straight_writes got=%0d exp=4", writes_n - w0); end
    if (wr_data_log[w0] !== 32'h0006_0007) begin failures++; $display("FAIL straight_w0 got=%h exp=00060007", wr_data_log[w0]); end
    if (wr_data_log[w0+1] !== 32'h0004_0005) begin failures++; $display("FAIL straight_w1 got=%h exp=00040005", wr_data_log[w0+1]); end
    if (wr_data_log[w0+2] !== 32'h0002_0003) begin failures++; $display("FAIL straight_w2 got=%h exp=00020003", wr_data_log[w0+2]); end
    if (wr_data_log[w0+3] !== 32'h0000_0001) begin failures++; $display("FAIL straight_w3 got=%h exp=00000001", wr_data_log[w0+3]); end
    if (path_len !== 11'd8) begin failures++; $display("FAIL straight_path_len got=%0d exp=8", path_len); end
  endtask

  initial begin
    test_reset();
    test_basic("basic");
    test_single();
    test_edge_err();
    test_loop_limit();
    test_abort();
    test_basic("after_abort");
    test_straight8();
    checks++;
    if (bad_addr_n !== 0) begin failures++; $display("FAIL address_range bad=%0d exp=0", bad_addr_n); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/path_trace32.md
Name: path_trace32

Overview:
- Downstream consumer of the 32x32 wavefront fabric's direction map.
- Starting from a software-chosen destination node, it walks the packed 4-bit predecessor directions in memory back to the origin node.
- Each visited coordinate is written to a path buffer in memory.
- Shares the fabric's word-oriented memory transaction interface, control-register style and done interrupt.

Parameters:
ADDR_DIR, 32'h40002000, base of direction map (128 words, 8 nibbles/word, nibble n = node n, node = y*32+x)
ADDR_PATH, 32'h40003000, base of path output buffer (max 512 words)
MAX_STEPS, 1024, step limit before loop error

Ports:
clk  in  1  clock
arst_n  in  1  async reset, active low
ctrl_wr  in  1  control register write strobe
ctrl_in  in  32  [31] run, [9:5] dest_y, [4:0] dest_x
ctrl_out  out  32  {run, 15'd0, done, err, 4'd0, dest_y, dest_x} (done=bit15, err=bit14)
path_len  out  11  entries emitted by last/current trace
txn_rdy  in  1  transaction complete pulse (read data valid same cycle)
txn_rdata  in  32  read data
txn_wdata  out  32  write data
txn_addr  out  32  word-aligned byte address
txn_req  out  1  one-cycle request pulse
txn_wr  out  1  1=write, valid with txn_req
int_done  out  1  one-cycle done pulse

Behaviour:
- Interface: one clock clk; reset arst_n asynchronous, active low.
- Reset: state IDLE; run, done, err, dest, path_len, txn_req, txn_wr, int_done all 0; txn_addr, txn_wdata 0.
- Direction codes (predecessor): 0 ORIGIN, 1 N (y-1), 2 E (x+1), 3 S (y+1), 4 W (x-1); 5-15 invalid.
- ctrl_wr when idle: loads run and dest; run=1 clears done, err and path_len.
- ctrl_wr with run=1 while busy: ignored.
- ctrl_wr with run=0 while busy: abort. Any outstanding transaction waits for txn_rdy, then IDLE; no int_done; done stays 0.
- States:
  - IDLE: run=1 -> cur=dest, lane=0, wr_idx=0, FETCH.
  - FETCH: txn_req=1, txn_wr=0, txn_addr=ADDR_DIR+{cur[9:3],2'b00} -> RD_WAIT.
  - RD_WAIT: hold until txn_rdy; latch txn_rdata -> DECODE.
  - DECODE:
    - d = word[cur[2:0]*4 +: 4].
    - Write entry {6'd0,cur_y,cur_x} into pack buffer lane (lane0=[15:0], lane1=[31:16]); path_len++.
    - Terminal cases:
      - d==ORIGIN: terminal ok.
      - d invalid, or move leaves grid (x=0&W, x=31&E, y=0&N, y=31&S): terminal err.
      - path_len reaches MAX_STEPS with d!=ORIGIN: terminal err.
    - lane1 filled or terminal -> WRITE; else lane=1, cur=next -> FETCH.
  - WRITE: txn_req=1, txn_wr=1, txn_addr=ADDR_PATH+{wr_idx,2'b00}, txn_wdata=buffer -> WR_WAIT.
  - WR_WAIT: on txn_rdy wr_idx++, buffer=0, lane=0; terminal -> DONE, else cur=next -> FETCH.
  - DONE: done=1, err per cause, run=0, int_done=1 for one cycle -> IDLE.
- Partial final word: unused upper lane written as 0.
- txn_wdata is stable from WRITE until txn_rdy.
- Any txn_rdy arriving in IDLE/DECODE is ignored.
- Latency per step without cache: 1 (FETCH) + memory latency + 1 (DECODE); plus 2 + memory latency per output word.
- Dest equal to origin node: one entry, path_len=1, one write.

Optional Feature:
- Macro TRACE_CACHE_EN.
- With it: the last fetched word and its index cur[9:3] are held with a valid bit, cleared on run start and on abort. FETCH with a matching index skips the read and goes directly to DECODE (1 cycle).
- Without it: every step issues a read.
- Path contents, path_len, done and err are identical either way; only transaction count and timing differ.

Decomposition:
- Shared package (also used by the fabric): direction code constants, ADDR_DIR/ADDR_MAP/ADDR_PATH defaults, grid dimension 32, nibble pack helpers.
- One natural sub-module: path_step32 (combinational), coord + dir -> next coord, bad flag.

Test Plan:
- Map: node2=W, node1=W, node0=ORIGIN; dest (2,0) -> writes 0x00010002 @ADDR_PATH, 0x00000000 @+4; path_len=3; done=1, err=0; one int_done pulse.
- Dest (5,3) with nibble=ORIGIN -> single write 0x00000065 @ADDR_PATH; path_len=1.
- Dest (0,4) dir=W -> entry 0x0080 written; err=1, done=1, path_len=1.
- Nodes 0 and 1 point at each other (E/W), no origin -> err after path_len=1024; 512 writes.
- Abort: ctrl_wr 0x00000000 during RD_WAIT with txn_rdy delayed 5 cycles -> IDLE after txn_rdy; no int_done; done=0.
- TRACE_CACHE_EN: straight 8-node run inside one word -> 1 read instead of 8; identical path data.
